// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline stages.
package mips_pipe_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned JADDR_W = 26;
    localparam int unsigned STATE_W = 1;

    typedef logic [WORD_W-1:0] word_t;

    localparam logic [STATE_W-1:0] ST_FETCH  = 1'b0;
    localparam logic [STATE_W-1:0] ST_SQUASH = 1'b1;

    localparam word_t RESET_PC_DEF = 32'h0000_0000;
    localparam word_t NOP_INST_DEF = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// Redirect detection and target priority mux (branch > jr > jump).
module next_pc_sel
    import mips_pipe_pkg::*;
(
    input  logic                 branch_taken,
    input  logic [WORD_W-1:0]    branch_target,
    input  logic                 jr,
    input  logic [WORD_W-1:0]    jr_target,
    input  logic                 jump,
    input  logic [JADDR_W-1:0]   jmp_adrs,
    input  logic [WORD_W-1:0]    pc_id,
    output logic                 redirect_c,
    output logic [WORD_W-1:0]    target_c
);

    // Only the region bits of the ID-stage PC form part of a jump target.
    logic unused_pc_id;
    assign unused_pc_id = ^pc_id[27:0];

    // Priority select of the redirect target.
    always_comb begin
        redirect_c = branch_taken | jr | jump;
        target_c   = {pc_id[31:28], jmp_adrs, 2'b00};
        if (branch_taken) begin
            target_c = branch_target;
        end else if (jr) begin
            target_c = jr_target;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, imem handshake
// and the outputs consumed by the IF/ID register.
module if_fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        IF_stall,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    input  logic        Jump,
    input  logic [25:0] Jmp_Adrs_ID,
    input  logic [31:0] PC_ID,
    input  logic        Jr,
    input  logic [31:0] Jr_target,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic        Imem_ready,
    input  logic [31:0] Imem_rdata,
    output logic [31:0] Inst,
    output logic [31:0] PC_4,
    output logic        Inst_valid,
    output logic        IF_Flush
);

    logic [STATE_W-1:0] state_q, state_d;
    word_t              pc_q, pc_d;
    word_t              squash_addr_q, squash_addr_d;
    word_t              inst_q, inst_d;
    word_t              pc_4_q, pc_4_d;
    logic               inst_valid_q, inst_valid_d;
    logic               if_flush_q, if_flush_d;

    logic               redirect_c;
    word_t              target_c;
    word_t              pc_plus4_c;
    logic               imem_req_c;
    logic               xfer_c;

    next_pc_sel u_next_pc_sel (
        .branch_taken  (Branch_taken),
        .branch_target (Branch_target),
        .jr            (Jr),
        .jr_target     (Jr_target),
        .jump          (Jump),
        .jmp_adrs      (Jmp_Adrs_ID),
        .pc_id         (PC_ID),
        .redirect_c    (redirect_c),
        .target_c      (target_c)
    );

    // Request is suppressed only while holding a valid instruction under stall;
    // a stale request being drained is never withdrawn.
    always_comb begin
        pc_plus4_c = pc_q + WORD_W'(4);
        imem_req_c = Rst_n & ((state_q == ST_SQUASH) | !(IF_stall & inst_valid_q));
        xfer_c     = imem_req_c & Imem_ready;
    end

    assign Imem_req  = imem_req_c;
    assign Imem_addr = (state_q == ST_SQUASH) ? squash_addr_q : pc_q;

    // Next-state and next-output logic for the FETCH/SQUASH machine.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        squash_addr_d = squash_addr_q;
        inst_d        = inst_q;
        pc_4_d        = pc_4_q;
        inst_valid_d  = inst_valid_q;
        if_flush_d    = 1'b0;

        if (state_q == ST_FETCH) begin
            if (redirect_c) begin
                pc_d         = target_c;
                if_flush_d   = 1'b1;
                inst_d       = NOP_INST;
                inst_valid_d = 1'b0;
                // An outstanding request must finish at its old address.
                if (imem_req_c && !Imem_ready) begin
                    squash_addr_d = pc_q;
                    state_d       = ST_SQUASH;
                end
            end else if (IF_stall && inst_valid_q) begin
                if_flush_d = 1'b0;
            end else if (xfer_c) begin
                inst_d       = Imem_rdata;
                pc_4_d       = pc_plus4_c;
                inst_valid_d = 1'b1;
                pc_d         = pc_plus4_c;
            end else begin
                inst_d       = NOP_INST;
                inst_valid_d = 1'b0;
            end
        end else begin
            inst_d       = NOP_INST;
            inst_valid_d = 1'b0;
            if (redirect_c) begin
                pc_d       = target_c;
                if_flush_d = 1'b1;
            end
            // Stale data is dropped; the new PC is fetched next.
            if (Imem_ready) begin
                state_d = ST_FETCH;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            squash_addr_q <= RESET_PC;
            inst_q        <= NOP_INST;
            pc_4_q        <= '0;
            inst_valid_q  <= 1'b0;
            if_flush_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            squash_addr_q <= squash_addr_d;
            inst_q        <= inst_d;
            pc_4_q        <= pc_4_d;
            inst_valid_q  <= inst_valid_d;
            if_flush_q    <= if_flush_d;
        end
    end

    assign Inst       = inst_q;
    assign PC_4       = pc_4_q;
    assign Inst_valid = inst_valid_q;
    assign IF_Flush   = if_flush_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for the instruction fetch stage.
module tb_if_fetch_stage;

    logic        Clk;
    logic        Rst_n;
    logic        IF_stall;
    logic        Branch_taken;
    logic [31:0] Branch_target;
    logic        Jump;
    logic [25:0] Jmp_Adrs_ID;
    logic [31:0] PC_ID;
    logic        Jr;
    logic [31:0] Jr_target;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ready;
    logic [31:0] Imem_rdata;
    logic [31:0] Inst;
    logic [31:0] PC_4;
    logic        Inst_valid;
    logic        IF_Flush;

    int vectors;
    int miscompares;

    if_fetch_stage dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .IF_stall      (IF_stall),
        .Branch_taken  (Branch_taken),
        .Branch_target (Branch_target),
        .Jump          (Jump),
        .Jmp_Adrs_ID   (Jmp_Adrs_ID),
        .PC_ID         (PC_ID),
        .Jr            (Jr),
        .Jr_target     (Jr_target),
        .Imem_req      (Imem_req),
        .Imem_addr     (Imem_addr),
        .Imem_ready    (Imem_ready),
        .Imem_rdata    (Imem_rdata),
        .Inst          (Inst),
        .PC_4          (PC_4),
        .Inst_valid    (Inst_valid),
        .IF_Flush      (IF_Flush)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        Rst_n         = 1'b0;
        IF_stall      = 1'b0;
        Branch_taken  = 1'b0;
        Branch_target = '0;
        Jump          = 1'b0;
        Jmp_Adrs_ID   = '0;
        PC_ID         = '0;
        Jr            = 1'b0;
        Jr_target     = '0;
        Imem_ready    = 1'b1;
        Imem_rdata    = 32'h2008_0005;

        // Reset state
        tick();
        tick();
        chk("rst_req",   32'(Imem_req),   32'd0);
        chk("rst_valid", 32'(Inst_valid), 32'd0);
        chk("rst_inst",  Inst,            32'h0);
        chk("rst_pc4",   PC_4,            32'h0);
        chk("rst_flush", 32'(IF_Flush),   32'd0);
        chk("rst_addr",  Imem_addr,       32'h0);

        // Zero-wait streaming after release
        Rst_n = 1'b1;
        #1;
        chk("rel_req",  32'(Imem_req), 32'd1);
        chk("rel_addr", Imem_addr,     32'h0);
        tick();
        chk("f0_inst",  Inst,            32'h2008_0005);
        chk("f0_pc4",   PC_4,            32'h4);
        chk("f0_valid", 32'(Inst_valid), 32'd1);
        chk("f0_addr",  Imem_addr,       32'h4);
        Imem_rdata = 32'hA000_0004;
        tick();
        chk("f1_inst", Inst,      32'hA000_0004);
        chk("f1_pc4",  PC_4,      32'h8);
        chk("f1_addr", Imem_addr, 32'h8);

        // Stall holds everything for three cycles
        IF_stall   = 1'b1;
        Imem_rdata = 32'hBAD0_0008;
        #1;
        chk("stl_req0", 32'(Imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_inst",  Inst,            32'hA000_0004);
            chk("stl_pc4",   PC_4,            32'h8);
            chk("stl_flush", 32'(IF_Flush),   32'd0);
            chk("stl_req",   32'(Imem_req),   32'd0);
            chk("stl_addr",  Imem_addr,       32'h8);
        end
        IF_stall   = 1'b0;
        Imem_rdata = 32'hA000_0008;
        tick();
        chk("res_inst", Inst,      32'hA000_0008);
        chk("res_pc4",  PC_4,      32'hC);
        chk("res_addr", Imem_addr, 32'hC);

        // Branch with zero-wait memory: one flushed slot
        Branch_taken  = 1'b1;
        Branch_target = 32'h40;
        Imem_rdata    = 32'hBAD0_000C;
        tick();
        chk("br_flush", 32'(IF_Flush),   32'd1);
        chk("br_valid", 32'(Inst_valid), 32'd0);
        chk("br_inst",  Inst,            32'h0);
        chk("br_addr",  Imem_addr,       32'h40);
        Branch_taken = 1'b0;
        Imem_rdata   = 32'hA000_0040;
        tick();
        chk("br1_flush", 32'(IF_Flush),   32'd0);
        chk("br1_valid", 32'(Inst_valid), 32'd1);
        chk("br1_inst",  Inst,            32'hA000_0040);
        chk("br1_pc4",   PC_4,            32'h44);

        // Redirect while a request at 0x10 is waiting
        Jr        = 1'b1;
        Jr_target = 32'h10;
        tick();
        chk("jr_flush", 32'(IF_Flush), 32'd1);
        chk("jr_addr",  Imem_addr,     32'h10);
        Jr         = 1'b0;
        Imem_ready = 1'b0;
        #1;
        chk("w_req", 32'(Imem_req), 32'd1);
        tick();
        chk("w_valid", 32'(Inst_valid), 32'd0);
        chk("w_flush", 32'(IF_Flush),   32'd0);
        chk("w_addr",  Imem_addr,       32'h10);
        Branch_taken  = 1'b1;
        Branch_target = 32'h80;
        tick();
        chk("sq_flush", 32'(IF_Flush),   32'd1);
        chk("sq_valid", 32'(Inst_valid), 32'd0);
        chk("sq_addr",  Imem_addr,       32'h10);
        Branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("sqw_addr",  Imem_addr,       32'h10);
            chk("sqw_req",   32'(Imem_req),   32'd1);
            chk("sqw_flush", 32'(IF_Flush),   32'd0);
            chk("sqw_valid", 32'(Inst_valid), 32'd0);
        end
        Imem_ready = 1'b1;
        Imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("sqd_valid", 32'(Inst_valid), 32'd0);
        chk("sqd_inst",  Inst,            32'h0);
        chk("sqd_addr",  Imem_addr,       32'h80);
        Imem_rdata = 32'hA000_0080;
        tick();
        chk("nw_valid", 32'(Inst_valid), 32'd1);
        chk("nw_inst",  Inst,            32'hA000_0080);
        chk("nw_pc4",   PC_4,            32'h84);

        // Redirect priority: branch > jr > jump
        Branch_taken  = 1'b1;
        Branch_target = 32'h100;
        Jr            = 1'b1;
        Jr_target     = 32'h200;
        Jump          = 1'b1;
        Jmp_Adrs_ID   = 26'h40;
        PC_ID         = 32'h1000_0000;
        tick();
        chk("pri_all",   Imem_addr,     32'h100);
        chk("pri_flush", 32'(IF_Flush), 32'd1);
        Branch_taken = 1'b0;
        tick();
        chk("pri_jr",     Imem_addr,     32'h200);
        chk("pri_flush2", 32'(IF_Flush), 32'd1);
        Jr = 1'b0;
        tick();
        chk("pri_jump", Imem_addr, 32'h1000_0100);
        Jump       = 1'b0;
        Imem_rdata = 32'hA010_0100;
        tick();
        chk("jmp_valid", 32'(Inst_valid), 32'd1);
        chk("jmp_pc4",   PC_4,            32'h1000_0104);
        chk("jmp_flush", 32'(IF_Flush),   32'd0);

        // PC wrap at the top of the address space
        Jr        = 1'b1;
        Jr_target = 32'hFFFF_FFFC;
        tick();
        Jr         = 1'b0;
        Imem_rdata = 32'hA000_FFFC;
        tick();
        chk("wrap_inst", Inst,      32'hA000_FFFC);
        chk("wrap_pc4",  PC_4,      32'h0);
        chk("wrap_addr", Imem_addr, 32'h0);

        // Reset in the middle of a wait at 0x20
        Jr        = 1'b1;
        Jr_target = 32'h20;
        tick();
        Jr         = 1'b0;
        Imem_ready = 1'b0;
        tick();
        chk("mw_addr",  Imem_addr,       32'h20);
        chk("mw_valid", 32'(Inst_valid), 32'd0);
        Rst_n = 1'b0;
        #1;
        chk("mr_req0", 32'(Imem_req), 32'd0);
        tick();
        chk("mr_req",   32'(Imem_req),   32'd0);
        chk("mr_valid", 32'(Inst_valid), 32'd0);
        chk("mr_addr",  Imem_addr,       32'h0);
        chk("mr_flush", 32'(IF_Flush),   32'd0);
        Imem_ready = 1'b1;
        Imem_rdata = 32'hBAD0_0020;
        tick();
        chk("late_valid", 32'(Inst_valid), 32'd0);
        chk("late_inst",  Inst,            32'h0);
        Rst_n      = 1'b1;
        Imem_rdata = 32'hA000_0000;
        tick();
        chk("rr_valid", 32'(Inst_valid), 32'd1);
        chk("rr_inst",  Inst,            32'hA000_0000);
        chk("rr_pc4",   PC_4,            32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
